// File: rtl/phase_error_quantizer_if.sv
// Edge-timing bus between the clock inputs and the quantized phase-error result.
// The master side drives the asynchronous clocks; the slave side returns magnitude, lead and strobe.
interface phase_error_quantizer_if #(
  parameter int inout_width = 8
);
  logic                   ref_in;
  logic                   fb_in;
  logic [inout_width-1:0] master_out;
  logic                   lead;
  logic                   valid;

  modport master (output ref_in, fb_in, input master_out, lead, valid);
  modport slave  (input ref_in, fb_in, output master_out, lead, valid);
endinterface

// File: rtl/phase_error_quantizer.sv
// Measures the clk-cycle separation between reference and feedback rising edges.
// Outputs a saturating unsigned magnitude plus a lead flag and a one-cycle valid strobe.
module phase_error_quantizer #(
  parameter int inout_width = 8,
  parameter int sync_stages = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  phase_error_quantizer_if.slave  bus
);
  localparam logic [inout_width-1:0] SAT = '1;
  localparam logic [inout_width-1:0] ONE = inout_width'(1);

  typedef enum logic [1:0] {IDLE, REF_FIRST, FB_FIRST} state_t;

  // Channel 0 is the reference, channel 1 the feedback; both share one latency.
  logic [1:0]                  async_in;
  logic [1:0][sync_stages-1:0] sync_q, sync_d;
  logic [1:0]                  prev_q, prev_d;
  logic [1:0]                  rise;
  logic                        ref_rise, fb_rise;

  state_t                 state_q, state_d;
  logic [inout_width-1:0] cnt_q, cnt_d, cnt_inc;
  logic [inout_width-1:0] master_out_q, master_out_d;
  logic                   lead_q, lead_d;
  logic                   valid_q, valid_d;

  assign async_in = {bus.fb_in, bus.ref_in};
  assign ref_rise = rise[0];
  assign fb_rise  = rise[1];

  always_comb begin
    sync_d = sync_q;
    prev_d = prev_q;
    rise   = '0;
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][sync_stages-2:0], async_in[i]};
      prev_d[i] = sync_q[i][sync_stages-1];
      rise[i]   = sync_q[i][sync_stages-1] & ~prev_q[i];
    end
  end

  assign cnt_inc = (cnt_q == SAT) ? SAT : cnt_q + ONE;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    master_out_d = master_out_q;
    lead_d       = lead_q;
    valid_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          master_out_d = '0;
          valid_d      = 1'b1;
        end else if (ref_rise) begin
          cnt_d   = ONE;
          state_d = REF_FIRST;
        end else if (fb_rise) begin
          cnt_d   = ONE;
          state_d = FB_FIRST;
        end
      end
      REF_FIRST: begin
        if (fb_rise) begin
          master_out_d = cnt_q;
          lead_d       = 1'b0;
          valid_d      = 1'b1;
          cnt_d        = ONE;
          state_d      = ref_rise ? REF_FIRST : IDLE;
        end else if (ref_rise) begin
          // Feedback edge went missing: report full scale and restart from this edge.
          master_out_d = SAT;
          lead_d       = 1'b0;
          valid_d      = 1'b1;
          cnt_d        = ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FB_FIRST: begin
        if (ref_rise) begin
          master_out_d = cnt_q;
          lead_d       = 1'b1;
          valid_d      = 1'b1;
          cnt_d        = ONE;
          state_d      = fb_rise ? FB_FIRST : IDLE;
        end else if (fb_rise) begin
          master_out_d = SAT;
          lead_d       = 1'b1;
          valid_d      = 1'b1;
          cnt_d        = ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q       <= '0;
      prev_q       <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      master_out_q <= '0;
      lead_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      master_out_q <= master_out_d;
      lead_q       <= lead_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.master_out = master_out_q;
  assign bus.lead       = lead_q;
  assign bus.valid      = valid_q;
endmodule

// File: tb/tb_phase_error_quantizer.sv
// Bench for phase_error_quantizer: directed scenarios plus random edges against a timestamp model.
module tb_phase_error_quantizer;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  phase_error_quantizer_if #(.inout_width(W)) bus();
  phase_error_quantizer #(.inout_width(W), .sync_stages(S)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: rises are timestamped by capture edge; a publish lands S edges later.
  typedef struct { int due; int mag; bit ld; } pub_t;
  pub_t q[$];
  int   pend;      // 0 none, 1 ref waiting, 2 fb waiting
  int   t0;
  bit   r_prev, f_prev, last_ld;
  int   exp_mo;
  bit   exp_lead, exp_valid;

  task automatic model_reset();
    pend = 0; t0 = 0; r_prev = 0; f_prev = 0; last_ld = 0;
    q.delete(); exp_mo = 0; exp_lead = 0; exp_valid = 0;
  endtask

  task automatic push(input int mag, input bit ld);
    pub_t p;
    p.due = cyc + S; p.mag = (mag > MAXV) ? MAXV : mag; p.ld = ld;
    q.push_back(p);
    last_ld = ld;
  endtask

  task automatic model_capture(input bit r, input bit f);
    bit rr, fr;
    pub_t p;
    rr = r & ~r_prev; fr = f & ~f_prev;
    r_prev = r; f_prev = f;
    if (pend == 0) begin
      if (rr && fr)  push(0, last_ld);
      else if (rr) begin pend = 1; t0 = cyc; end
      else if (fr) begin pend = 2; t0 = cyc; end
    end else if (pend == 1) begin
      if (fr) begin push(cyc - t0, 0); if (rr) t0 = cyc; else pend = 0; end
      else if (rr) begin push(MAXV, 0); t0 = cyc; end
    end else begin
      if (rr) begin push(cyc - t0, 1); if (fr) t0 = cyc; else pend = 0; end
      else if (fr) begin push(MAXV, 1); t0 = cyc; end
    end
    exp_valid = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      p = q.pop_front();
      exp_valid = 1; exp_mo = p.mag; exp_lead = p.ld;
    end
  endtask

  // One clk cycle: inputs change at negedge, capture at posedge, outputs sampled 1 ns later.
  task automatic step(input bit r, input bit f);
    @(negedge clk);
    bus.ref_in = r; bus.fb_in = f;
    @(posedge clk);
    cyc++;
    if (rstn) model_capture(r, f);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.ref_in = 1'b0; bus.fb_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    total++; if (bus.master_out !== '0) begin bad++; $display("FAIL reset_mo got=%0d want=0", bus.master_out); end
    total++; if (bus.lead !== 1'b0) begin bad++; $display("FAIL reset_lead got=%b want=0", bus.lead); end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_ref_leads();
    int nv = 0; int mo = -1; bit ld = 1;
    for (int i = 0; i < 20; i++) begin
      step(i < 14, i >= 5 && i < 14);
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL ref_leads cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
      if (bus.valid) begin nv++; mo = int'(bus.master_out); ld = bus.lead; end
    end
    total++; if (nv != 1 || mo != 5 || ld !== 1'b0) begin
      bad++; $display("FAIL ref_leads_result got n=%0d mo=%0d ld=%b want n=1 mo=5 ld=0", nv, mo, ld);
    end
    total++; if (bus.master_out !== W'(5) || bus.lead !== 1'b0) begin
      bad++; $display("FAIL ref_leads_hold got mo=%0d ld=%b want mo=5 ld=0", bus.master_out, bus.lead);
    end
  endtask

  task automatic test_fb_leads();
    int nv = 0; int mo = -1; bit ld = 0; int rcap = 0; int vcyc = 0;
    for (int i = 0; i < 40; i++) begin
      step(i >= 12 && i < 30, i < 30);
      if (i == 12) rcap = cyc;
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL fb_leads cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
      if (bus.valid) begin nv++; mo = int'(bus.master_out); ld = bus.lead; vcyc = cyc; end
    end
    total++; if (nv != 1 || mo != 12 || ld !== 1'b1) begin
      bad++; $display("FAIL fb_leads_result got n=%0d mo=%0d ld=%b want n=1 mo=12 ld=1", nv, mo, ld);
    end
    total++; if (vcyc != rcap + S) begin
      bad++; $display("FAIL fb_leads_latency got edge=%0d want edge=%0d", vcyc, rcap + S);
    end
  endtask

  task automatic test_simultaneous();
    int nv = 0; int mo = -1; bit ld = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 6, i < 6);
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL simul cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
      if (bus.valid) begin nv++; mo = int'(bus.master_out); ld = bus.lead; end
    end
    total++; if (nv != 1 || mo != 0 || ld !== 1'b1) begin
      bad++; $display("FAIL simul_result got n=%0d mo=%0d ld=%b want n=1 mo=0 ld=1", nv, mo, ld);
    end
  endtask

  task automatic test_saturation();
    int nv = 0; int mo[2]; bit ld[2];
    mo[0] = -1; mo[1] = -1; ld[0] = 1; ld[1] = 1;
    for (int i = 0; i < 330; i++) begin
      step(i < 320, i >= 300 && i < 320);
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL sat cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
      if (bus.valid) begin nv++; mo[0] = int'(bus.master_out); ld[0] = bus.lead; end
    end
    total++; if (nv != 1 || mo[0] != MAXV || ld[0] !== 1'b0) begin
      bad++; $display("FAIL sat_result got n=%0d mo=%0d ld=%b want n=1 mo=%0d ld=0", nv, mo[0], ld[0], MAXV);
    end
    // Two reference rises with no feedback in between, then feedback 3 cycles after the second.
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 3 || (i >= 6 && i < 14), i >= 9 && i < 14);
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL missing cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
      if (bus.valid) begin
        if (nv < 2) begin mo[nv] = int'(bus.master_out); ld[nv] = bus.lead; end
        nv++;
      end
    end
    total++; if (nv != 2 || mo[0] != MAXV || mo[1] != 3 || ld[0] !== 1'b0 || ld[1] !== 1'b0) begin
      bad++; $display("FAIL missing_result got n=%0d mo0=%0d mo1=%0d want n=2 mo0=%0d mo1=3", nv, mo[0], mo[1], MAXV);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0; int mo = -1; bit ld = 1;
    // Feedback-first pair leaves lead=1, then a reference edge opens a long measurement.
    for (int i = 0; i < 52; i++) begin
      step((i >= 4 && i < 6) || i >= 10, i < 8);
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL pre_reset cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
    end
    total++; if (bus.master_out !== W'(4) || bus.lead !== 1'b1) begin
      bad++; $display("FAIL pre_reset_state got mo=%0d ld=%b want mo=4 ld=1", bus.master_out, bus.lead);
    end
    #2 rstn = 1'b0;
    #1;
    total++; if ({bus.valid, bus.master_out, bus.lead} !== '0) begin
      bad++; $display("FAIL reset_mid_async got v=%b mo=%0d ld=%b want all 0", bus.valid, bus.master_out, bus.lead);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid got=%b want=0", bus.valid); end
    end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(i >= 2 && i < 15, i >= 9 && i < 15);
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL post_reset cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
      if (bus.valid) begin nv++; mo = int'(bus.master_out); ld = bus.lead; end
    end
    total++; if (nv != 1 || mo != 7 || ld !== 1'b0) begin
      bad++; $display("FAIL post_reset_result got n=%0d mo=%0d ld=%b want n=1 mo=7 ld=0", nv, mo, ld);
    end
  endtask

  task automatic test_random();
    bit r = 0, f = 0;
    int nv = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) r = ~r;
      if ($urandom_range(0, 5) == 0) f = ~f;
      step(r, f);
      total++;
      if ({bus.valid, bus.master_out, bus.lead} !== {exp_valid, W'(exp_mo), exp_lead}) begin
        bad++; $display("FAIL random cyc=%0d got v=%b mo=%0d ld=%b want v=%b mo=%0d ld=%b",
                        cyc, bus.valid, bus.master_out, bus.lead, exp_valid, exp_mo, exp_lead);
      end
      if (bus.valid) nv++;
    end
    total++; if (nv < 100) begin bad++; $display("FAIL random_activity got=%0d publishes want>=100", nv); end
  endtask

  initial begin
    test_reset();
    test_ref_leads();
    test_fb_leads();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phase_error_quantizer.md
# phase_error_quantizer

Front end of the ADPLL digital path: measures the time between rising edges of the reference clock and the DCO feedback clock. Counts the separation in sampling-clock cycles and presents it as an unsigned magnitude plus a lead flag. Its outputs use the same format the third-order loop filter consumes on its `master_in`/`lead` inputs, with a one-cycle valid strobe per measurement.

## Interface
- `inout_width`, default 8: magnitude width; saturation value is 2^inout_width − 1.
- `sync_stages`, default 2: synchronizer depth on each asynchronous input, minimum 2.
- `clk`  input  1  sampling clock; all logic on its rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `ref_in`  input  1  reference clock, asynchronous to `clk`.
- `fb_in`  input  1  divided DCO feedback clock, asynchronous to `clk`.
- `master_out`  output  `inout_width`  unsigned edge separation in `clk` cycles, registered.
- `lead`  output  1  1 = feedback edge came first; 0 = reference edge came first. Registered.
- `valid`  output  1  one-cycle pulse when `master_out`/`lead` update.

## Operation
- **Input conditioning**
  - Each input passes through a `sync_stages` flop chain, then one `prev` flop.
  - `ref_rise` = synced & ~prev, computed combinationally. `fb_rise` is formed the same way.
  - Both paths have identical latency, so edge separation is preserved.
- **Counter**
  - `cnt` is `inout_width` bits and saturates at max; it never wraps.
- **FSM states:** IDLE, REF_FIRST, FB_FIRST.
- **IDLE**
  - `ref_rise` & `fb_rise`: publish `master_out`=0, `lead` unchanged, `valid`=1. Stay in IDLE.
  - `ref_rise` only: `cnt`←1, go to REF_FIRST.
  - `fb_rise` only: `cnt`←1, go to FB_FIRST.
- **REF_FIRST**
  - No edge: `cnt`←sat(`cnt`+1).
  - `fb_rise` (with or without `ref_rise`): publish `master_out`=`cnt`, `lead`=0, `valid`=1.
    - Then go to IDLE, or with simultaneous `ref_rise` re-enter REF_FIRST with `cnt`←1.
  - `ref_rise` without `fb_rise` (missing feedback edge): publish saturation value, `lead`=0, `valid`=1. Re-enter REF_FIRST with `cnt`←1.
- **FB_FIRST:** mirror of REF_FIRST with the roles of `ref`/`fb` swapped and `lead`=1.
- **Hold:** `master_out`/`lead` hold their values between publishes. `valid`=0 in every non-publishing cycle.

## Timing
- **Reset** clears all of the following to 0 immediately and asynchronously:
  - all synchronizer flops, `prev` flops and `cnt`;
  - the FSM (to IDLE);
  - `master_out`, `lead`, `valid`.
- **Reset mid-measurement:** the measurement is discarded and no `valid` is produced.
- **Input high at reset release:** an input that is high when reset releases is detected as a rising edge `sync_stages` cycles later. This is intentional.
- **Magnitude:** a rise seen at internal cycle t, with the other rise at t+N, gives `master_out`=min(N, max).
- **Latency:** an input edge first captured at `clk` edge k produces its rise flag during the cycle after edge k+`sync_stages`−1. The corresponding publish is registered at edge k+`sync_stages`.
- **Valid rate:** back-to-back publishes are possible, at most one per cycle.
- **Resolution:** ±1 `clk` cycle. This comes from the synchronizer sampling uncertainty.

## Test plan
- **Ref leads:** `ref_in` rises, then `fb_in` rises 5 `clk` cycles later → one `valid` pulse with `master_out`=5, `lead`=0. Outputs then hold.
- **Fb leads:** `fb_in` rises, then `ref_in` rises 12 `clk` cycles later → `master_out`=12, `lead`=1. `valid` asserts exactly `sync_stages` edges after `ref_in` is captured.
- **Simultaneous edges:** both inputs rise on the same `clk` edge → `master_out`=0, `valid`=1, `lead` keeps its previous value.
- **Saturation and missing edge:**
  - Separation of 300 cycles with default width → `master_out`=255, `lead`=0.
  - Two `ref` rises with no `fb` in between → `valid` with 255; the next `fb` rise 3 cycles later → `master_out`=3.
- **Reset:** pulse `rstn` low during REF_FIRST with `cnt`=40 → all outputs 0 at once, no `valid`. After release, a clean pair 7 cycles apart → `master_out`=7.
